// File: rtl/dvi_timing_gen.sv
// Parametrised raster timing and test-pattern source. The pixel rate is a clock-enable
// strobe from an integer divider; all video outputs register on that strobe.
module dvi_timing_gen #(
  parameter int CLK_DIV  = 3,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_rgb,
  output logic             pix_ce,
  output logic [23:0]      rgb,
  output logic             rgb_de,
  output logic             hsync,
  output logic             vsync,
  output logic             sof,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] h, v, bar_cnt;
  logic [2:0]       bar_idx;
  logic [1:0]       mode_q, cur_mode;
  logic             de_c;
  logic [7:0]       ramp;
  logic [23:0]      bar_rgb, pat;

  assign tick = (div_cnt == DIV_LAST);
  assign ramp = 8'(h);

  always_comb begin
    // The origin pixel already uses the newly sampled mode.
    cur_mode = (h == '0 && v == '0) ? mode : mode_q;
    de_c     = (h < H_ACT) && (v < V_ACT);
    bar_rgb  = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pat = 24'h000000;
    case (cur_mode)
      2'd0:    pat = solid_rgb;
      2'd1:    pat = bar_rgb;
      2'd2:    pat = {3{ramp}};
      default: pat = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
      h       <= '0;
      v       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      rgb     <= '0;
      rgb_de  <= 1'b0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
      sof     <= 1'b0;
      h_pos   <= '0;
      v_pos   <= '0;
      if (rst) mode_q <= 2'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      pix_ce  <= tick;
      if (tick) begin
        rgb    <= de_c ? pat : 24'h000000;
        rgb_de <= de_c;
        hsync  <= (h >= HS_BEG && h < HS_END) ? HS_POL : ~HS_POL;
        vsync  <= (v >= VS_BEG && v < VS_END) ? VS_POL : ~VS_POL;
        sof    <= (h == '0) && (v == '0);
        h_pos  <= h;
        v_pos  <= v;
        mode_q <= cur_mode;
        if (h == H_LAST) begin
          h       <= '0;
          v       <= (v == V_LAST) ? '0 : v + 1'b1;
          bar_cnt <= '0;
          bar_idx <= '0;
        end else begin
          h <= h + 1'b1;
          // Bar 7 never advances, so it absorbs any remainder of H_ACTIVE/8.
          if (bar_idx != 3'd7) begin
            if (bar_cnt == BAR_LAST) begin
              bar_cnt <= '0;
              bar_idx <= bar_idx + 1'b1;
            end else begin
              bar_cnt <= bar_cnt + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
